// File: rtl/temp_log_frame_packer_pkg.sv
// Shared types and ASCII constants for the temperature log frame packer.
package temp_log_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        HDR,
        DATA,
        CHK,
        EOL
    } phase_t;

    localparam logic [7:0] ASC_DOLLAR = 8'h24;
    localparam logic [7:0] ASC_T      = 8'h54;
    localparam logic [7:0] ASC_COLON  = 8'h3A;
    localparam logic [7:0] ASC_COMMA  = 8'h2C;
    localparam logic [7:0] ASC_STAR   = 8'h2A;
    localparam logic [7:0] ASC_CR     = 8'h0D;
    localparam logic [7:0] ASC_LF     = 8'h0A;

endpackage

// File: rtl/temp_log_frame_packer_if.sv
// Byte link between the frame packer (master) and uart_tx (slave).
// Handshake: master pulses tx_start for one cycle only while uart_busy is low; tx_data stays valid until uart_busy falls.
interface temp_log_frame_packer_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       uart_busy;

    modport master (output tx_start, output tx_data, input uart_busy);
    modport slave  (input tx_start, input tx_data, output uart_busy);

endinterface

// File: rtl/temp_log_frame_packer_hex_nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
module hex_nibble_to_ascii (
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end

endmodule

// File: rtl/temp_log_frame_packer.sv
// Serialises a captured sample snapshot into one ASCII log line for uart_tx.
// Optional build macro PKT_CHECKSUM_EN adds a '*'+XOR checksum before CR LF.
module temp_log_frame_packer
    import temp_log_pkt_pkg::*;
#(
    parameter int NUM_SAMPLES = 10,
    parameter int DATA_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_SAMPLES*DATA_W-1:0] samples_flat,
    temp_log_frame_packer_if.master       uart,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          drop,
    output state_t                        dbg_state
);

    localparam int NIBS  = DATA_W / 4;
    localparam int CNT_W = (NIBS > 8) ? $clog2(NIBS) : 3;
    localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] NIB_TOP  = CNT_W'(NIBS - 1);
    localparam logic [IDX_W-1:0] LAST_SMP = IDX_W'(NUM_SAMPLES - 1);

    state_t                          state;
    phase_t                          phase;
    logic [CNT_W-1:0]                cnt;
    logic [IDX_W-1:0]                smp_idx;
    logic                            sep;
    logic [7:0]                      seq;
    logic [NUM_SAMPLES*DATA_W-1:0]   snap;
    logic [7:0]                      tx_data_q;
    logic                            tx_start_q;
    logic [DATA_W-1:0]               cur_sample;
    logic [3:0]                      nib;
    logic [7:0]                      hex_char;
    logic [7:0]                      next_byte;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]                      chk;
`endif

    assign uart.tx_start = tx_start_q;
    assign uart.tx_data  = tx_data_q;
    assign dbg_state     = state;

    hex_nibble_to_ascii u_hex (
        .nib   (nib),
        .ascii (hex_char)
    );

    // One converter serves sequence, data and checksum digits, so the nibble is muxed here.
    always_comb begin
        cur_sample = snap[smp_idx*DATA_W +: DATA_W];
        nib        = 4'h0;
        next_byte  = ASC_LF;
        case (phase)
            HDR: begin
                nib = (cnt == CNT_W'(2)) ? seq[7:4] : seq[3:0];
                case (cnt)
                    CNT_W'(0): next_byte = ASC_DOLLAR;
                    CNT_W'(1): next_byte = ASC_T;
                    CNT_W'(2),
                    CNT_W'(3): next_byte = hex_char;
                    default:   next_byte = ASC_COLON;
                endcase
            end
            DATA: begin
                nib       = cur_sample[cnt*4 +: 4];
                next_byte = sep ? ASC_COMMA : hex_char;
            end
`ifdef PKT_CHECKSUM_EN
            CHK: begin
                nib       = (cnt == CNT_W'(1)) ? chk[7:4] : chk[3:0];
                next_byte = (cnt == CNT_W'(0)) ? ASC_STAR : hex_char;
            end
`endif
            EOL: next_byte = (cnt == CNT_W'(0)) ? ASC_CR : ASC_LF;
            default: next_byte = ASC_LF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= HDR;
            cnt        <= '0;
            smp_idx    <= '0;
            sep        <= 1'b0;
            seq        <= '0;
            snap       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            drop       <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            chk        <= '0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            frame_done <= 1'b0;
            drop       <= start && (state != IDLE);
            case (state)
                IDLE: if (start) begin
                    snap    <= samples_flat;
                    busy    <= 1'b1;
                    phase   <= HDR;
                    cnt     <= '0;
                    smp_idx <= '0;
                    sep     <= 1'b0;
`ifdef PKT_CHECKSUM_EN
                    chk     <= '0;
`endif
                    state   <= LOAD;
                end
                LOAD: begin
                    tx_data_q <= next_byte;
                    if (!uart.uart_busy) begin
                        tx_start_q <= 1'b1;
                        state      <= STROBE;
                    end
                end
                STROBE:  state <= WAIT_HI;
                WAIT_HI: if (uart.uart_busy) state <= WAIT_LO;
                WAIT_LO: if (!uart.uart_busy) begin
`ifdef PKT_CHECKSUM_EN
                    if ((phase == HDR && cnt != '0) || phase == DATA) chk <= chk ^ tx_data_q;
`endif
                    state <= LOAD;
                    case (phase)
                        HDR: if (cnt == CNT_W'(4)) begin
                            phase <= DATA;
                            cnt   <= NIB_TOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                        DATA: if (sep) begin
                            sep     <= 1'b0;
                            smp_idx <= smp_idx + 1'b1;
                            cnt     <= NIB_TOP;
                        end else if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (smp_idx != LAST_SMP) begin
                            sep <= 1'b1;
                        end else begin
`ifdef PKT_CHECKSUM_EN
                            phase <= CHK;
`else
                            phase <= EOL;
`endif
                            cnt <= '0;
                        end
`ifdef PKT_CHECKSUM_EN
                        CHK: if (cnt == CNT_W'(2)) begin
                            phase <= EOL;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                        EOL: if (cnt != '0) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                        default: state <= LOAD;
                    endcase
                end
                DONE: begin
                    seq   <= seq + 8'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_log_frame_packer.sv
// Directed bench for temp_log_frame_packer: a 10-sample instance and a 1-sample instance, each with a uart_tx model.
module tb_temp_log_frame_packer;
  import temp_log_pkt_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, start_b;
  logic [79:0] smp_a;
  logic [7:0]  smp_b;
  logic        busy_a, fd_a, drop_a, busy_b, fd_b, drop_b;
  state_t      st_a, st_b;

  temp_log_frame_packer_if bus_a ();
  temp_log_frame_packer_if bus_b ();

  temp_log_frame_packer #(.NUM_SAMPLES(10), .DATA_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .samples_flat(smp_a), .uart(bus_a),
    .busy(busy_a), .frame_done(fd_a), .drop(drop_a), .dbg_state(st_a));

  temp_log_frame_packer #(.NUM_SAMPLES(1), .DATA_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .samples_flat(smp_b), .uart(bus_b),
    .busy(busy_b), .frame_done(fd_b), .drop(drop_b), .dbg_state(st_b));

  // uart_tx models: busy rises the cycle after tx_start and stays up two cycles
  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  logic [7:0] held_a = 8'h00, held_b = 8'h00;
  logic       hold_a = 1'b0;
  logic       prev_a = 1'b0, prev_b = 1'b0;
  int bcnt_a = 0, bcnt_b = 0;
  int strobes_a = 0, strobes_b = 0, done_a = 0, done_b = 0, drops_a = 0, proto_err = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      bcnt_a = 0; bcnt_b = 0; prev_a = 1'b0; prev_b = 1'b0;
    end else begin
      if (bus_a.tx_start) begin
        if (bus_a.uart_busy || prev_a) proto_err++;
        rx_a.push_back(bus_a.tx_data); held_a = bus_a.tx_data; bcnt_a = 2; strobes_a++;
      end else if (bcnt_a != 0) begin
        if (bus_a.tx_data != held_a) proto_err++;
        bcnt_a--;
      end
      if (bus_b.tx_start) begin
        if (bus_b.uart_busy || prev_b) proto_err++;
        rx_b.push_back(bus_b.tx_data); held_b = bus_b.tx_data; bcnt_b = 2; strobes_b++;
      end else if (bcnt_b != 0) begin
        if (bus_b.tx_data != held_b) proto_err++;
        bcnt_b--;
      end
      prev_a = bus_a.tx_start;
      prev_b = bus_b.tx_start;
      if (fd_a) done_a++;
      if (fd_b) done_b++;
      if (drop_a) drops_a++;
    end
    bus_a.uart_busy = hold_a || (bcnt_a != 0);
    bus_b.uart_busy = (bcnt_b != 0);
  end

  // scoreboard
  int total = 0;
  int bad = 0;

  function automatic string vis(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++)
      r = (s[i] < 8'h20) ? {r, $sformatf("<%0d>", s[i])} : {r, $sformatf("%c", s[i])};
    return r;
  endfunction

  function automatic string hex2(logic [7:0] v);
    string d = "0123456789ABCDEF";
    return $sformatf("%c%c", d[v[7:4]], d[v[3:0]]);
  endfunction

  // Expected full frame from its body ("$T..:data"); checksum is XOR of everything after '$'.
  function automatic string frame(string body);
`ifdef PKT_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 1; i < body.len(); i++) x = x ^ body[i];
    return {body, "*", hex2(x), "\015\012"};
`else
    return {body, "\015\012"};
`endif
  endfunction

  function automatic string grab(bit sel, int from);
    string r = "";
    int n = sel ? rx_b.size() : rx_a.size();
    for (int i = from; i < n; i++) r = {r, $sformatf("%c", sel ? rx_b[i] : rx_a[i])};
    return r;
  endfunction

  task automatic check_str(input string name, input string got, input string exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got \"%s\" required \"%s\"", name, vis(got), vis(exp));
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // driver: one start pulse, optional mid-frame disturbance and uart_busy hold-off
  task automatic run_frame(input bit sel, input logic [79:0] s, input int disturb, input int hold_cyc,
                           output string got, output int n_strobe, output int n_done, output int n_drop);
    int i0, s0, d0, p0;
    bit ok;
    ok = 1'b0;
    i0 = sel ? rx_b.size() : rx_a.size();
    s0 = sel ? strobes_b : strobes_a;
    d0 = sel ? done_b : done_a;
    p0 = drops_a;
    if (hold_cyc > 0) begin
      hold_a = 1'b1;
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    if (sel) begin smp_b = s[7:0]; start_b = 1'b1; end
    else begin smp_a = s; start_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int k = 1; k <= 4000 && !ok; k++) begin
      @(negedge clk);
      if (!sel) start_a = (disturb > 0 && k == disturb);
      if (disturb > 0 && k == disturb) smp_a = ~s;
      if (hold_cyc > 0 && k == hold_cyc) begin
        check_int("hold_no_strobe", strobes_a - s0, 0);
        check_int("hold_busy", int'(busy_a), 1);
        check_int("hold_state_load", int'(st_a), int'(LOAD));
        hold_a = 1'b0;
      end
      if (sel ? fd_b : fd_a) ok = 1'b1;
    end
    check_int("frame_done_timeout", int'(ok), 1);
    @(negedge clk);
    got      = grab(sel, i0);
    n_strobe = (sel ? strobes_b : strobes_a) - s0;
    n_done   = (sel ? done_b : done_a) - d0;
    n_drop   = drops_a - p0;
  endtask

  typedef struct {
    string       name;
    logic [79:0] smp;
    int          disturb;
    int          hold;
    string       body;
  } vec_t;

  vec_t  vecs[5];
  string got, exp;
  int    ns, nd, np, s0;
  bit    ok;

  initial begin
    vecs[0] = '{"zeros",   80'h0, 0, 0, "$T00:00,00,00,00,00,00,00,00,00,00"};
    vecs[1] = '{"ramp_af", 80'hAF_08_07_06_05_04_03_02_01_00, 0, 0, "$T01:00,01,02,03,04,05,06,07,08,AF"};
    vecs[2] = '{"ramp_af2", 80'hAF_08_07_06_05_04_03_02_01_00, 0, 0, "$T02:00,01,02,03,04,05,06,07,08,AF"};
    vecs[3] = '{"midframe", 80'hC3_5A_F0_DE_BC_9A_78_56_34_12, 40, 0, "$T03:12,34,56,78,9A,BC,DE,F0,5A,C3"};
    vecs[4] = '{"busyhold", 80'h01_23_45_67_89_AB_CD_EF_FE_DC, 0, 50, "$T04:DC,FE,EF,CD,AB,89,67,45,23,01"};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; smp_a = '0; smp_b = '0;
    repeat (3) @(negedge clk);
    check_int("rst_tx_start", int'(bus_a.tx_start), 0);
    check_int("rst_tx_data", int'(bus_a.tx_data), 0);
    check_int("rst_busy", int'(busy_a), 0);
    check_int("rst_frame_done", int'(fd_a), 0);
    check_int("rst_drop", int'(drop_a), 0);
    check_int("rst_state", int'(st_a), int'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // table-driven frames on the 10-sample instance
    for (int v = 0; v < 5; v++) begin
      run_frame(1'b0, vecs[v].smp, vecs[v].disturb, vecs[v].hold, got, ns, nd, np);
      exp = frame(vecs[v].body);
      check_str({vecs[v].name, "_frame"}, got, exp);
      check_int({vecs[v].name, "_strobes"}, ns, exp.len());
      check_int({vecs[v].name, "_done"}, nd, 1);
      check_int({vecs[v].name, "_drop"}, np, (vecs[v].disturb > 0) ? 1 : 0);
      if (v == 0) begin
`ifdef PKT_CHECKSUM_EN
        check_int("zeros_len", got.len(), 39);
`else
        check_int("zeros_len", got.len(), 36);
`endif
      end
    end

    // single-sample instance: hand-computed frame, then sequence wrap over 256 frames
`ifdef PKT_CHECKSUM_EN
    exp = "$T00:3A*1C\015\012";
`else
    exp = "$T00:3A\015\012";
`endif
    run_frame(1'b1, 80'h3A, 0, 0, got, ns, nd, np);
    check_str("one_sample_frame", got, exp);
    for (int f = 1; f < 256; f++) begin
      run_frame(1'b1, 80'h3A, 0, 0, got, ns, nd, np);
      check_str($sformatf("seq_frame_%0d", f), got, frame({"$T", hex2(8'(f)), ":3A"}));
    end
    run_frame(1'b1, 80'h3A, 0, 0, got, ns, nd, np);
    check_str("seq_wrap_257", got, exp);

    // reset while waiting for uart_busy to fall
    s0 = strobes_a;
    @(negedge clk); smp_a = 80'hAF_08_07_06_05_04_03_02_01_00; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (st_a == WAIT_LO && strobes_a - s0 >= 5) ok = 1'b1;
    end
    check_int("reach_wait_lo", int'(ok), 1);
    rst = 1'b1; #1;
    check_int("rst_wait_lo_tx_start", int'(bus_a.tx_start), 0);
    check_int("rst_wait_lo_busy", int'(busy_a), 0);
    check_int("rst_wait_lo_state", int'(st_a), int'(IDLE));
    @(negedge clk); rst = 1'b0;

    // reset in the middle of the strobe cycle
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (bus_a.tx_start) ok = 1'b1;
    end
    check_int("reach_strobe", int'(ok), 1);
    rst = 1'b1; #1;
    check_int("rst_strobe_tx_start", int'(bus_a.tx_start), 0);
    check_int("rst_strobe_tx_data", int'(bus_a.tx_data), 0);
    @(negedge clk); rst = 1'b0;

    run_frame(1'b0, 80'h0, 0, 0, got, ns, nd, np);
    check_str("after_reset_frame", got, frame("$T00:00,00,00,00,00,00,00,00,00,00"));
    check_int("protocol_errors", proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
